// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the round-robin memory arbiter:
//   state_t   - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   GNT_A/B   - grant encoding, also stored as the "last grant" bit
//   OP_WRITE/READ - value of the write_read field for each operation
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GNT_A    = 1'b0;
  localparam logic GNT_B    = 1'b1;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

endpackage : mem_pkg

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   req_a, req_b  in   request from port A / port B
//   last_grant    in   port granted most recently (GNT_A / GNT_B)
//   gnt_valid     out  at least one request present
//   gnt_id        out  chosen port; on a tie, the port that did not win last
// -----------------------------------------------------------------------------
module rr_pick2
  import mem_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first) so no latch can be inferred.
  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = GNT_A;
    if (req_a && req_b) begin
      gnt_id = ~last_grant;
    end else if (req_b) begin
      gnt_id = GNT_B;
    end
  end

endmodule : rr_pick2

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// Two-requester round-robin arbiter and sequencer in front of a single-port
// synchronous memory. One transaction at a time: grant, one-cycle mem_valid_o
// pulse, wait for mem_ready_i (bounded by TIMEOUT), one-cycle completion pulse
// to the granted requester. All outputs are registered.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   a_/b_valid_i                  request, held stable until *_ready_o
//   a_/b_write_read_i             1 = write, 0 = read
//   a_/b_addr_i, a_/b_write_data_i  address and write data
//   a_/b_ready_o                  one-cycle completion pulse
//   a_/b_read_data_o              read data, valid with *_ready_o on a read
//   a_/b_err_o                    timeout flag, valid with *_ready_o
//   mem_valid_o .. mem_write_data_o  request to the memory
//   mem_ready_i, mem_read_data_i  response from the memory
// -----------------------------------------------------------------------------
module mem_rr_arbiter
  import mem_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // port A
  input  logic                  a_valid_i,
  input  logic                  a_write_read_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [WIDTH-1:0]      a_write_data_i,
  output logic                  a_ready_o,
  output logic [WIDTH-1:0]      a_read_data_o,
  output logic                  a_err_o,
  // port B
  input  logic                  b_valid_i,
  input  logic                  b_write_read_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [WIDTH-1:0]      b_write_data_i,
  output logic                  b_ready_o,
  output logic [WIDTH-1:0]      b_read_data_o,
  output logic                  b_err_o,
  // memory side
  output logic                  mem_valid_o,
  output logic                  mem_write_read_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_write_data_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_read_data_i
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_mem_valid, w_mem_valid_nxt;
  logic                  r_mem_wr, w_mem_wr_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [WIDTH-1:0]      r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_a_ready, w_a_ready_nxt, r_b_ready, w_b_ready_nxt;
  logic                  r_a_err, w_a_err_nxt, r_b_err, w_b_err_nxt;
  logic [WIDTH-1:0]      r_a_rdata, w_a_rdata_nxt, r_b_rdata, w_b_rdata_nxt;

  logic                  w_gnt_valid, w_gnt_id;
  logic                  w_fire, w_fire_err;
  logic [WIDTH-1:0]      w_fire_rdata;

  rr_pick2 u_pick (
    .req_a      (a_valid_i),
    .req_b      (b_valid_i),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_gnt_valid) w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = WAIT;
      WAIT:  if (mem_ready_i || (r_cnt == CNT_LAST)) w_state_nxt = RESP;
      RESP:  w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and grant history.
  always_comb begin
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_mem_valid_nxt  = r_mem_valid;
    w_mem_wr_nxt     = r_mem_wr;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_a_ready_nxt    = r_a_ready;
    w_a_err_nxt      = r_a_err;
    w_a_rdata_nxt    = r_a_rdata;
    w_b_ready_nxt    = r_b_ready;
    w_b_err_nxt      = r_b_err;
    w_b_rdata_nxt    = r_b_rdata;
    w_fire           = 1'b0;
    w_fire_err       = 1'b0;
    w_fire_rdata     = '0;

    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_last_grant_nxt = w_gnt_id;
          w_mem_valid_nxt  = 1'b1;
          if (w_gnt_id == GNT_A) begin
            w_mem_wr_nxt    = a_write_read_i;
            w_mem_addr_nxt  = a_addr_i;
            w_mem_wdata_nxt = a_write_data_i;
          end else begin
            w_mem_wr_nxt    = b_write_read_i;
            w_mem_addr_nxt  = b_addr_i;
            w_mem_wdata_nxt = b_write_data_i;
          end
        end
      end
      ISSUE: begin
        w_mem_valid_nxt = 1'b0;
        w_cnt_nxt       = '0;
      end
      WAIT: begin
        // A ready arriving on the last allowed cycle still wins over timeout.
        if (mem_ready_i) begin
          w_fire       = 1'b1;
          w_fire_rdata = (r_mem_wr == OP_READ) ? mem_read_data_i : '0;
        end else if (r_cnt == CNT_LAST) begin
          w_fire     = 1'b1;
          w_fire_err = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        w_a_ready_nxt = 1'b0;
        w_a_err_nxt   = 1'b0;
        w_a_rdata_nxt = '0;
        w_b_ready_nxt = 1'b0;
        w_b_err_nxt   = 1'b0;
        w_b_rdata_nxt = '0;
      end
    endcase

    // r_last_grant holds the port owning the in-flight transaction.
    if (w_fire) begin
      if (r_last_grant == GNT_A) begin
        w_a_ready_nxt = 1'b1;
        w_a_err_nxt   = w_fire_err;
        w_a_rdata_nxt = w_fire_rdata;
      end else begin
        w_b_ready_nxt = 1'b1;
        w_b_err_nxt   = w_fire_err;
        w_b_rdata_nxt = w_fire_rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_grant <= GNT_B;  // A wins the first tie after reset
      r_cnt        <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_a_ready    <= 1'b0;
      r_a_err      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_ready    <= 1'b0;
      r_b_err      <= 1'b0;
      r_b_rdata    <= '0;
    end else begin
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_a_ready    <= w_a_ready_nxt;
      r_a_err      <= w_a_err_nxt;
      r_a_rdata    <= w_a_rdata_nxt;
      r_b_ready    <= w_b_ready_nxt;
      r_b_err      <= w_b_err_nxt;
      r_b_rdata    <= w_b_rdata_nxt;
    end
  end

  assign mem_valid_o      = r_mem_valid;
  assign mem_write_read_o = r_mem_wr;
  assign mem_addr_o       = r_mem_addr;
  assign mem_write_data_o = r_mem_wdata;
  assign a_ready_o        = r_a_ready;
  assign a_err_o          = r_a_err;
  assign a_read_data_o    = r_a_rdata;
  assign b_ready_o        = r_b_ready;
  assign b_err_o          = r_b_err;
  assign b_read_data_o    = r_b_rdata;

endmodule : mem_rr_arbiter

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
// Directed bench for mem_rr_arbiter with a behavioural single-port memory whose
// response delay is programmable per transaction. Single-port transactions come
// from a vector table; ties, starvation, reset and stray-ready cases are
// hand-written sequences. Edges are counted from the first rising edge after
// valid is raised (that edge is the grant edge).
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;
  import mem_pkg::*;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid, a_wr, b_valid, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_wdata, b_wdata;
  logic          a_ready, a_err, b_ready, b_err;
  logic [7:0]    a_rdata, b_rdata;
  logic          mem_valid, mem_wr, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .a_valid_i        (a_valid),
    .a_write_read_i   (a_wr),
    .a_addr_i         (a_addr),
    .a_write_data_i   (a_wdata),
    .a_ready_o        (a_ready),
    .a_read_data_o    (a_rdata),
    .a_err_o          (a_err),
    .b_valid_i        (b_valid),
    .b_write_read_i   (b_wr),
    .b_addr_i         (b_addr),
    .b_write_data_i   (b_wdata),
    .b_ready_o        (b_ready),
    .b_read_data_o    (b_rdata),
    .b_err_o          (b_err),
    .mem_valid_o      (mem_valid),
    .mem_write_read_o (mem_wr),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_wdata),
    .mem_ready_i      (mem_ready),
    .mem_read_data_i  (mem_rdata)
  );

  // Behavioural memory: ready pulses (mem_delay+1) edges after valid is seen.
  logic [7:0] mem_q [DEPTH];
  int         pend;
  int         mem_delay = 0;
  logic       stray = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 0;
      mem_rdata <= '0;
    end else if (mem_valid) begin
      pend <= mem_delay + 1;
      if (mem_wr) mem_q[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_q[mem_addr];
    end else if (pend > 0) begin
      pend <= pend - 1;
    end
  end

  assign mem_ready = (pend == 1) | stray;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       port;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         delay;
    logic [7:0] exp_rd;
    logic       exp_err;
    int         exp_edges;
  } vec_t;

  vec_t vecs [10];

  task automatic run_txn(input vec_t v, input int idx);
    int   n;
    logic got, other, rdy, err;
    logic [7:0] rd;
    n = 0; got = 1'b0; other = 1'b0; rdy = 1'b0; err = 1'b0; rd = '0;
    mem_delay = v.delay;
    if (v.port == GNT_A) begin
      a_valid = 1'b1; a_wr = v.wr; a_addr = v.addr; a_wdata = v.wdata;
    end else begin
      b_valid = 1'b1; b_wr = v.wr; b_addr = v.addr; b_wdata = v.wdata;
    end
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        check($sformatf("v%0d mem_valid pulse", idx), int'(mem_valid), 1);
        check($sformatf("v%0d mem_addr", idx), int'(mem_addr), int'(v.addr));
        check($sformatf("v%0d mem_op", idx), int'(mem_wr), int'(v.wr));
        if (v.wr == OP_WRITE)
          check($sformatf("v%0d mem_wdata", idx), int'(mem_wdata), int'(v.wdata));
      end
      if (n == 2) check($sformatf("v%0d mem_valid drop", idx), int'(mem_valid), 0);
      rdy = (v.port == GNT_A) ? a_ready : b_ready;
      if ((v.port == GNT_A) ? b_ready : a_ready) other = 1'b1;
      if (rdy) begin
        got = 1'b1;
        rd  = (v.port == GNT_A) ? a_rdata : b_rdata;
        err = (v.port == GNT_A) ? a_err : b_err;
      end
    end
    check($sformatf("v%0d latency", idx), n, v.exp_edges);
    check($sformatf("v%0d read_data", idx), int'(rd), int'(v.exp_rd));
    check($sformatf("v%0d err", idx), int'(err), int'(v.exp_err));
    check($sformatf("v%0d other port quiet", idx), int'(other), 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    check($sformatf("v%0d ready cleared", idx),
          int'((v.port == GNT_A) ? a_ready : b_ready), 0);
    check($sformatf("v%0d back to idle", idx), int'(dut.r_state), int'(IDLE));
    mem_delay = 0;
  endtask

  // Both ports held valid as reads; each drops valid when its ready is seen.
  // Expected: A ready at edge 3, B at edge 7.
  task automatic tie_once(input string tag, input logic [7:0] exp_a, input logic [7:0] exp_b);
    int a_e, b_e;
    a_e = -1; b_e = -1;
    a_valid = 1'b1; a_wr = OP_READ; a_addr = 4'd1;
    b_valid = 1'b1; b_wr = OP_READ; b_addr = 4'd2;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (a_ready && a_e < 0) begin
        a_e = e; a_valid = 1'b0;
        check({tag, " A data"}, int'(a_rdata), int'(exp_a));
      end
      if (b_ready && b_e < 0) begin
        b_e = e; b_valid = 1'b0;
        check({tag, " B data"}, int'(b_rdata), int'(exp_b));
      end
    end
    check({tag, " A edge"}, a_e, 3);
    check({tag, " B edge"}, b_e, 7);
  endtask

  initial begin
    int a_e, b_e, a_cnt, b_cnt, a_first, a_second;
    logic seen;

    vecs[0] = '{GNT_A, OP_WRITE, 4'd3,  8'h5A, 0, 8'h00, 1'b0, 3};
    vecs[1] = '{GNT_A, OP_READ,  4'd3,  8'h00, 0, 8'h5A, 1'b0, 3};
    vecs[2] = '{GNT_B, OP_WRITE, 4'd7,  8'hC3, 0, 8'h00, 1'b0, 3};
    vecs[3] = '{GNT_B, OP_READ,  4'd7,  8'h00, 0, 8'hC3, 1'b0, 3};
    vecs[4] = '{GNT_A, OP_READ,  4'd7,  8'h00, 0, 8'hC3, 1'b0, 3};
    vecs[5] = '{GNT_B, OP_WRITE, 4'd5,  8'hA5, 2, 8'h00, 1'b0, 5};
    vecs[6] = '{GNT_A, OP_READ,  4'd5,  8'h00, 7, 8'hA5, 1'b0, TIMEOUT + 2}; // ready on last WAIT cycle
    vecs[7] = '{GNT_B, OP_READ,  4'd5,  8'h00, 8, 8'h00, 1'b1, TIMEOUT + 2}; // timeout; late ready ignored
    vecs[8] = '{GNT_A, OP_WRITE, 4'd15, 8'hFF, 0, 8'h00, 1'b0, 3};
    vecs[9] = '{GNT_B, OP_READ,  4'd15, 8'h00, 0, 8'hFF, 1'b0, 3};

    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;

    // Reset values.
    tick(); tick();
    check("reset mem_valid", int'(mem_valid), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset mem_wdata", int'(mem_wdata), 0);
    check("reset ready", int'({a_ready, b_ready}), 0);
    check("reset err", int'({a_err, b_err}), 0);
    check("reset rdata", int'({a_rdata, b_rdata}), 0);
    check("reset state", int'(dut.r_state), int'(IDLE));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

    // Simultaneous writes held from reset: A (last_grant=B after reset) first.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    a_e = -1; b_e = -1;
    a_valid = 1'b1; a_wr = OP_WRITE; a_addr = 4'd1; a_wdata = 8'h11;
    b_valid = 1'b1; b_wr = OP_WRITE; b_addr = 4'd2; b_wdata = 8'h22;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (a_ready && a_e < 0) begin a_e = e; a_valid = 1'b0; end
      if (b_ready && b_e < 0) begin b_e = e; b_valid = 1'b0; end
    end
    check("tie wr A edge", a_e, 3);
    check("tie wr B edge", b_e, 7);

    // Both held valid continuously as reads: grants alternate A,B,A,B.
    a_cnt = 0; b_cnt = 0;
    a_valid = 1'b1; a_wr = OP_READ; a_addr = 4'd1;
    b_valid = 1'b1; b_wr = OP_READ; b_addr = 4'd2;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (a_ready) begin
        a_cnt++;
        check("alt A slot", e % 8, 3);
        check("alt A data", int'(a_rdata), 8'h11);
      end
      if (b_ready) begin
        b_cnt++;
        check("alt B slot", e % 8, 7);
        check("alt B data", int'(b_rdata), 8'h22);
      end
      if (e == 14) begin a_valid = 1'b0; b_valid = 1'b0; end
    end
    check("alt A count", a_cnt, 2);
    check("alt B count", b_cnt, 2);
    check("alt idle", int'(dut.r_state), int'(IDLE));

    // Starvation: A held valid, B raised once while A is in flight.
    a_first = -1; a_second = -1; b_e = -1;
    a_valid = 1'b1; a_wr = OP_READ; a_addr = 4'd1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 1) begin b_valid = 1'b1; b_wr = OP_READ; b_addr = 4'd2; end
      if (a_ready) begin
        if (a_first < 0) a_first = e;
        else if (a_second < 0) begin a_second = e; a_valid = 1'b0; end
      end
      if (b_ready && b_e < 0) begin
        b_e = e; b_valid = 1'b0;
        check("starve B data", int'(b_rdata), 8'h22);
      end
    end
    check("starve A first", a_first, 3);
    check("starve B edge", b_e, 7);
    check("starve A second", a_second, 11);

    // Reset while mem_valid_o is high drops it without a clock edge.
    b_valid = 1'b1; b_wr = OP_READ; b_addr = 4'd2;
    tick();
    check("issue mem_valid", int'(mem_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async drop mem_valid", int'(mem_valid), 0);
    b_valid = 1'b0;
    tick(); rst_n = 1'b1;

    // Reset during WAIT on a B read: no completion ever appears.
    mem_delay = 4;
    b_valid = 1'b1; b_wr = OP_READ; b_addr = 4'd2;
    tick(); tick();
    check("wait state reached", int'(dut.r_state), int'(WAIT));
    rst_n = 1'b0;
    #1;
    check("rst wait state", int'(dut.r_state), int'(IDLE));
    check("rst wait mem_valid", int'(mem_valid), 0);
    b_valid = 1'b0;
    tick(); rst_n = 1'b1;
    mem_delay = 0;
    seen = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (b_ready || a_ready) seen = 1'b1;
    end
    check("rst no ready pulse", int'(seen), 0);

    // First tie after reset goes to A again.
    tie_once("post-rst tie", 8'h11, 8'h22);

    // Stray mem_ready_i while idle.
    seen = 1'b0;
    stray = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (a_ready || b_ready || mem_valid) seen = 1'b1;
    end
    stray = 1'b0;
    check("stray no response", int'(seen), 0);
    check("stray idle", int'(dut.r_state), int'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_rr_arbiter
